// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns byte-addressed pipeline requests into word-wide
// memory cycles, with read-modify-write for sub-word stores and extension for sub-word loads.
module mem_access_unit #(
   parameter int LEN_ADDR = 32,
   parameter int LEN_DATA = 32,
   parameter int MEM_AW   = 11
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_load,
   input  logic                req_store,
   input  logic [1:0]          req_size,
   input  logic                req_signed,
   input  logic [LEN_ADDR-1:0] req_addr,
   input  logic [LEN_DATA-1:0] req_wdata,
   output logic                rsp_valid,
   output logic [LEN_DATA-1:0] rsp_rdata,
   output logic                rsp_err,
   output logic                mem_rd,
   output logic                mem_wr,
   output logic [MEM_AW-1:0]   mem_addr,
   output logic [LEN_DATA-1:0] mem_wdata,
   input  logic [LEN_DATA-1:0] mem_rdata
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LD_ADDR   = 3'd1;
   localparam logic [2:0] S_LD_DATA   = 3'd2;
   localparam logic [2:0] S_RMW_ADDR  = 3'd3;
   localparam logic [2:0] S_RMW_MERGE = 3'd4;
   localparam logic [2:0] S_ST_WR     = 3'd5;
   localparam logic [2:0] S_RESP      = 3'd6;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   logic [2:0]          r_state;
   logic [1:0]          r_size;
   logic [1:0]          r_lane;
   logic                r_signed;
   logic                r_err;
   logic [15:0]         r_wdata;

   logic                r_rsp_valid;
   logic [LEN_DATA-1:0] r_rsp_rdata;
   logic                r_rsp_err;
   logic                r_mem_rd;
   logic                r_mem_wr;
   logic [MEM_AW-1:0]   r_mem_addr;
   logic [LEN_DATA-1:0] r_mem_wdata;

   logic                w_idle;
   logic                w_accept;
   logic                w_err_size;
   logic                w_err_kind;
   logic                w_err_align;
   logic                w_req_err;
   logic [7:0]          w_rd_byte [4];
   logic [3:0]          w_wr_sel;
   logic [LEN_DATA-1:0] w_merged;
   logic [7:0]          w_ld_byte;
   logic [15:0]         w_ld_half;
   logic [LEN_DATA-1:0] w_load_data;
   logic                w_unused;

   assign w_idle    = (r_state == S_IDLE);
   assign w_accept  = req_valid && w_idle;
   assign req_ready = w_idle;

   assign w_err_size  = (req_size == 2'b11);
   assign w_err_kind  = (req_load == req_store);
   assign w_err_align = ((req_size == SZ_HALF) && req_addr[0]) ||
                        ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
   assign w_req_err   = w_err_size || w_err_kind || w_err_align;

   // Upper address bits fall outside the memory window; addresses simply wrap.
   assign w_unused = &{1'b0, req_addr[LEN_ADDR-1:MEM_AW+2]};

   // Per-lane view of the read word and the store merge; halfword stores
   // cover the lane pair selected by the upper lane bit.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         assign w_rd_byte[gi] = mem_rdata[8*gi +: 8];
         assign w_wr_sel[gi]  = (r_size == SZ_BYTE) ? (r_lane == LANE)
                                                    : (r_lane[1] == LANE[1]);
         assign w_merged[8*gi +: 8] = !w_wr_sel[gi] ? w_rd_byte[gi] :
                                      ((r_size == SZ_HALF) && LANE[0]) ? r_wdata[15:8]
                                                                       : r_wdata[7:0];
      end
   endgenerate

   assign w_ld_byte = w_rd_byte[r_lane];
   assign w_ld_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   always_comb begin
      w_load_data = mem_rdata;
      case (r_size)
         SZ_BYTE: w_load_data = {{(LEN_DATA-8){r_signed & w_ld_byte[7]}}, w_ld_byte};
         SZ_HALF: w_load_data = {{(LEN_DATA-16){r_signed & w_ld_half[15]}}, w_ld_half};
         default: w_load_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_size      <= SZ_BYTE;
         r_lane      <= 2'b00;
         r_signed    <= 1'b0;
         r_err       <= 1'b0;
         r_wdata     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_mem_rd    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         // Strobes are single-cycle unless a state explicitly raises them.
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_mem_rd    <= 1'b0;
         r_mem_wr    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_size      <= req_size;
                  r_lane      <= req_addr[1:0];
                  r_signed    <= req_signed;
                  r_wdata     <= req_wdata[15:0];
                  r_err       <= w_req_err;
                  r_rsp_rdata <= '0;
                  if (w_req_err) begin
                     r_state <= S_RESP;
                  end else if (req_load) begin
                     r_mem_rd   <= 1'b1;
                     r_mem_addr <= req_addr[MEM_AW+1:2];
                     r_state    <= S_LD_ADDR;
                  end else if (req_size == SZ_WORD) begin
                     r_mem_wr    <= 1'b1;
                     r_mem_addr  <= req_addr[MEM_AW+1:2];
                     r_mem_wdata <= req_wdata;
                     r_state     <= S_ST_WR;
                  end else begin
                     r_mem_rd   <= 1'b1;
                     r_mem_addr <= req_addr[MEM_AW+1:2];
                     r_state    <= S_RMW_ADDR;
                  end
               end
            end
            S_LD_ADDR: r_state <= S_LD_DATA;
            S_LD_DATA: begin
               r_rsp_rdata <= w_load_data;
               r_state     <= S_RESP;
            end
            S_RMW_ADDR: r_state <= S_RMW_MERGE;
            S_RMW_MERGE: begin
               r_mem_wdata <= w_merged;
               r_mem_wr    <= 1'b1;
               r_state     <= S_ST_WR;
            end
            S_ST_WR: r_state <= S_RESP;
            S_RESP: begin
               r_rsp_valid <= 1'b1;
               r_rsp_err   <= r_err;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign mem_rd    = r_mem_rd;
   assign mem_wr    = r_mem_wr;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

   a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (!reset)
      !(r_mem_rd && r_mem_wr));

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized traffic
// checked against a byte-addressed reference memory.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_load = 1'b0;
   logic        req_store = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_rd;
   logic        mem_wr;
   logic [10:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.LEN_ADDR(32), .LEN_DATA(32), .MEM_AW(11)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_load  (req_load),
      .req_store (req_store),
      .req_size  (req_size),
      .req_signed(req_signed),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Word-wide synchronous data memory
   logic [31:0] tb_mem [0:2047];
   always @(posedge clk) begin
      if (mem_wr) tb_mem[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= tb_mem[mem_addr];
   end

   // Reference: byte-addressed memory, 8 KiB window, address wraps
   logic [7:0] ref_mem [0:8191];

   function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
      int unsigned base;
      int v;
      base = a & 32'h1FFF;
      if (sz == 2'd0) begin
         v = int'(ref_mem[base]);
         if (sg && v >= 128) v = v - 256;
      end else if (sz == 2'd1) begin
         v = int'(ref_mem[base]) + 256 * int'(ref_mem[base + 1]);
         if (sg && v >= 32768) v = v - 65536;
      end else begin
         return {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
      end
      return 32'(v);
   endfunction

   task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      int unsigned base;
      int n;
      base = a & 32'h1FFF;
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      for (int i = 0; i < n; i++) ref_mem[base + i] = 8'((wd >> (8 * i)) & 32'hFF);
   endtask

   function automatic logic ref_err(input logic ld, input logic st, input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'd3) || (ld == st) || (sz == 2'd1 && (a % 2) != 0) ||
             (sz == 2'd2 && (a % 4) != 0);
   endfunction

   function automatic int ref_lat(input logic ld, input logic [1:0] sz, input logic e);
      if (e) return 1;
      if (ld) return 3;
      if (sz == 2'd2) return 2;
      return 4;
   endfunction

   // Issue one request and observe it up to the response pulse.
   task automatic do_req(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int nrd, output int nwr, output logic [10:0] rd_addr,
                         output logic [10:0] wr_addr, output logic [31:0] wr_data);
      rdata = '0; err = 1'b0; lat = -1; nrd = 0; nwr = 0;
      rd_addr = '0; wr_addr = '0; wr_data = '0;
      for (int w = 0; w < 20 && !req_ready; w++) begin
         @(posedge clk); #1;
      end
      req_valid = 1'b1; req_load = ld; req_store = st; req_size = sz;
      req_signed = sg; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (mem_rd) begin nrd++; rd_addr = mem_addr; end
         if (mem_wr) begin nwr++; wr_addr = mem_addr; wr_data = mem_wdata; end
         if (rsp_valid) begin lat = c; rdata = rsp_rdata; err = rsp_err; break; end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
      checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b expected 0", mem_rd); end
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr: got %b expected 0", mem_wr); end
      checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
      checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
      checks++; if (mem_addr !== 11'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
      reset = 1'b1;
      @(posedge clk); #1;
      $display("reset: done");
   endtask

   task automatic test_word();
      logic [31:0] rd, wdat; logic er; int lat, nrd, nwr; logic [10:0] ra, wa;
      do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, rd, er, lat, nrd, nwr, ra, wa, wdat);
      ref_store(2'd2, 32'h40, 32'hDEADBEEF);
      $display("SW 0x40: lat=%0d wr_addr=%h wr_data=%h", lat, wa, wdat);
      checks++; if (wa !== 11'h010) begin errors++; $display("FAIL sw_mem_addr: got %h expected 010", wa); end
      checks++; if (nwr !== 1 || nrd !== 0) begin errors++; $display("FAIL sw_pulses: got rd=%0d wr=%0d expected rd=0 wr=1", nrd, nwr); end
      checks++; if (wdat !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h expected deadbeef", wdat); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d expected 2", lat); end
      do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd, er, lat, nrd, nwr, ra, wa, wdat);
      $display("LW 0x40: lat=%0d rdata=%h err=%b", lat, rd, er);
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata: got %h expected deadbeef", rd); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL lw_latency: got %0d expected 3", lat); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err: got %b expected 0", er); end
   endtask

   task automatic test_subword_loads();
      logic [31:0] rd, wdat; logic er; int lat, nrd, nwr; logic [10:0] ra, wa;
      logic [31:0] addrs [5] = '{32'h0, 32'h1, 32'h1, 32'h2, 32'h2};
      logic [1:0]  sizes [5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
      logic        sgns  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] exps  [5] = '{32'h0000007F, 32'hFFFFFFFF, 32'h000000FF, 32'hFFFF8000, 32'h00008000};
      do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h0, 32'h8000FF7F, rd, er, lat, nrd, nwr, ra, wa, wdat);
      ref_store(2'd2, 32'h0, 32'h8000FF7F);
      for (int i = 0; i < 5; i++) begin
         do_req(1'b1, 1'b0, sizes[i], sgns[i], addrs[i], 32'h0, rd, er, lat, nrd, nwr, ra, wa, wdat);
         $display("load size=%0d signed=%b addr=%h: rdata=%h lat=%0d", sizes[i], sgns[i], addrs[i], rd, lat);
         checks++; if (rd !== exps[i]) begin errors++; $display("FAIL subload_%0d: got %h expected %h", i, rd, exps[i]); end
         checks++; if (lat !== 3 || er !== 1'b0) begin errors++; $display("FAIL subload_lat_%0d: got lat=%0d err=%b expected lat=3 err=0", i, lat, er); end
      end
   endtask

   task automatic test_rmw();
      logic [31:0] rd, wdat; logic er; int lat, nrd, nwr; logic [10:0] ra, wa;
      do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, rd, er, lat, nrd, nwr, ra, wa, wdat);
      ref_store(2'd2, 32'h20, 32'h11223344);
      do_req(1'b0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AB, rd, er, lat, nrd, nwr, ra, wa, wdat);
      ref_store(2'd0, 32'h21, 32'hAB);
      $display("SB 0x21: lat=%0d rd=%0d wr=%0d merged=%h", lat, nrd, nwr, wdat);
      checks++; if (wdat !== 32'h1122AB44) begin errors++; $display("FAIL sb_merge: got %h expected 1122ab44", wdat); end
      checks++; if (lat !== 4 || nrd !== 1 || nwr !== 1) begin errors++; $display("FAIL sb_timing: got lat=%0d rd=%0d wr=%0d expected 4/1/1", lat, nrd, nwr); end
      checks++; if (ra !== 11'h008 || wa !== 11'h008) begin errors++; $display("FAIL sb_addr: got rd=%h wr=%h expected 008", ra, wa); end
      do_req(1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000CDEF, rd, er, lat, nrd, nwr, ra, wa, wdat);
      ref_store(2'd1, 32'h22, 32'hCDEF);
      $display("SH 0x22: lat=%0d rd=%0d wr=%0d merged=%h", lat, nrd, nwr, wdat);
      checks++; if (wdat !== 32'hCDEFAB44) begin errors++; $display("FAIL sh_merge: got %h expected cdefab44", wdat); end
      checks++; if (lat !== 4 || nrd !== 1 || nwr !== 1) begin errors++; $display("FAIL sh_timing: got lat=%0d rd=%0d wr=%0d expected 4/1/1", lat, nrd, nwr); end
      checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sh_rsp: got rdata=%h err=%b expected 0/0", rd, er); end
      do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat, nrd, nwr, ra, wa, wdat);
      checks++; if (rd !== 32'hCDEFAB44) begin errors++; $display("FAIL rmw_readback: got %h expected cdefab44", rd); end
   endtask

   task automatic test_errors();
      logic [31:0] rd, wdat; logic er; int lat, nrd, nwr; logic [10:0] ra, wa;
      logic        lds [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      logic        sts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [1:0]  szs [6] = '{2'd2, 2'd1, 2'd3, 2'd3, 2'd2, 2'd0};
      logic [31:0] ads [6] = '{32'h2, 32'h3, 32'h0, 32'h4, 32'h0, 32'h0};
      for (int i = 0; i < 6; i++) begin
         do_req(lds[i], sts[i], szs[i], 1'b1, ads[i], 32'hFFFFFFFF, rd, er, lat, nrd, nwr, ra, wa, wdat);
         $display("error case %0d: err=%b rdata=%h lat=%0d rd=%0d wr=%0d", i, er, rd, lat, nrd, nwr);
         checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_rsp_%0d: got err=%b rdata=%h expected 1/0", i, er, rd); end
         checks++; if (lat !== 1 || nrd !== 0 || nwr !== 0) begin errors++; $display("FAIL err_timing_%0d: got lat=%0d rd=%0d wr=%0d expected 1/0/0", i, lat, nrd, nwr); end
      end
   endtask

   task automatic test_busy_wrap();
      logic [31:0] rd, wdat; logic er; int lat, nrd, nwr, busy_bad; logic [10:0] ra, wa;
      do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h30, 32'h01020304, rd, er, lat, nrd, nwr, ra, wa, wdat);
      ref_store(2'd2, 32'h30, 32'h01020304);
      req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_size = 2'd0;
      req_signed = 1'b0; req_addr = 32'h33; req_wdata = 32'h77;
      @(posedge clk); #1;
      // Keep a different request pending while busy
      req_load = 1'b1; req_store = 1'b0; req_size = 2'd2; req_addr = 32'h30;
      lat = -1; nrd = 0; nwr = 0; busy_bad = 0;
      for (int c = 0; c < 20; c++) begin
         if (mem_rd) nrd++;
         if (mem_wr) nwr++;
         if (rsp_valid) begin lat = c; break; end
         if (req_ready !== 1'b0) busy_bad++;
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      ref_store(2'd0, 32'h33, 32'h77);
      $display("busy SB 0x33: lat=%0d rd=%0d wr=%0d ready_violations=%0d", lat, nrd, nwr, busy_bad);
      checks++; if (busy_bad !== 0) begin errors++; $display("FAIL busy_ready: got %0d cycles ready expected 0", busy_bad); end
      checks++; if (lat !== 4 || nrd !== 1 || nwr !== 1) begin errors++; $display("FAIL busy_timing: got lat=%0d rd=%0d wr=%0d expected 4/1/1", lat, nrd, nwr); end
      do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, rd, er, lat, nrd, nwr, ra, wa, wdat);
      checks++; if (rd !== ref_load(2'd2, 1'b0, 32'h30)) begin errors++; $display("FAIL busy_readback: got %h expected %h", rd, ref_load(2'd2, 1'b0, 32'h30)); end
      do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h00002000, 32'h0, rd, er, lat, nrd, nwr, ra, wa, wdat);
      $display("LW 0x2000: rd_addr=%h rdata=%h", ra, rd);
      checks++; if (ra !== 11'h000 || nrd !== 1) begin errors++; $display("FAIL wrap_addr: got %h (rd=%0d) expected 000", ra, nrd); end
      checks++; if (rd !== ref_load(2'd2, 1'b0, 32'h2000)) begin errors++; $display("FAIL wrap_rdata: got %h expected %h", rd, ref_load(2'd2, 1'b0, 32'h2000)); end
   endtask

   task automatic test_reset_mid_rmw();
      logic [31:0] rd, wdat; logic er; int lat, nrd, nwr, seen_rsp; logic [10:0] ra, wa;
      do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hA5A55A5A, rd, er, lat, nrd, nwr, ra, wa, wdat);
      ref_store(2'd2, 32'h10, 32'hA5A55A5A);
      req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_size = 2'd0;
      req_signed = 1'b0; req_addr = 32'h11; req_wdata = 32'h3C;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 0; c < 10 && !mem_wr; c++) begin
         @(posedge clk); #1;
      end
      checks++; if (mem_wr !== 1'b1) begin errors++; $display("FAIL rst_mid_reach_wr: got mem_wr=%b expected 1", mem_wr); end
      #2 reset = 1'b0;
      #1;
      checks++; if (mem_wr !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_drop: got wr=%b valid=%b ready=%b expected 0/0/1", mem_wr, rsp_valid, req_ready); end
      @(posedge clk); #1;
      reset = 1'b1;
      seen_rsp = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (rsp_valid) seen_rsp++;
      end
      checks++; if (seen_rsp !== 0) begin errors++; $display("FAIL rst_mid_no_rsp: got %0d responses expected 0", seen_rsp); end
      do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, nrd, nwr, ra, wa, wdat);
      $display("LW 0x10 after reset: rdata=%h", rd);
      checks++; if (rd !== ref_load(2'd2, 1'b0, 32'h10)) begin errors++; $display("FAIL rst_mid_word: got %h expected %h", rd, ref_load(2'd2, 1'b0, 32'h10)); end
   endtask

   task automatic test_random();
      logic [31:0] rd, wdat, a, wd, exp_rd; logic er, ld, st, sg, exp_err; logic [1:0] sz;
      int lat, nrd, nwr, exp_lat, k; logic [10:0] ra, wa;
      for (int w = 0; w < 32; w++) begin
         wd = $urandom;
         do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'(w * 4), wd, rd, er, lat, nrd, nwr, ra, wa, wdat);
         ref_store(2'd2, 32'(w * 4), wd);
      end
      for (int t = 0; t < 60; t++) begin
         k = $urandom_range(0, 9);
         ld = (k < 5); st = (k >= 5 && k < 9);
         if (k == 9) begin ld = 1'($urandom_range(0, 1)); st = ld; end
         k = $urandom_range(0, 15);
         sz = (k == 15) ? 2'd3 : 2'(k % 3);
         a = 32'($urandom_range(0, 127));
         if ($urandom_range(0, 3) != 0 && sz == 2'd1) a = a & ~32'h1;
         if ($urandom_range(0, 3) != 0 && sz == 2'd2) a = a & ~32'h3;
         if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_E000);
         sg = 1'($urandom_range(0, 1));
         wd = $urandom;
         exp_err = ref_err(ld, st, sz, a);
         exp_rd = (ld && !exp_err) ? ref_load(sz, sg, a) : 32'h0;
         exp_lat = ref_lat(ld, sz, exp_err);
         do_req(ld, st, sz, sg, a, wd, rd, er, lat, nrd, nwr, ra, wa, wdat);
         if (st && !exp_err) ref_store(sz, a, wd);
         $display("rand %0d: ld=%b st=%b sz=%0d sg=%b addr=%h wd=%h -> rdata=%h err=%b lat=%0d",
                  t, ld, st, sz, sg, a, wd, rd, er, lat);
         checks++; if (er !== exp_err) begin errors++; $display("FAIL rand_err_%0d: got %b expected %b", t, er, exp_err); end
         checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand_rdata_%0d: got %h expected %h", t, rd, exp_rd); end
         checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rand_lat_%0d: got %0d expected %0d", t, lat, exp_lat); end
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_subword_loads();
      test_rmw();
      test_errors();
      test_busy_wrap();
      test_reset_mid_rmw();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
